// File: rtl/map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | map_pkg                                                                    |
// | Shared map geometry, tile codes, probe FSM states and tile index helper.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package map_pkg;

    localparam int TILE_PX = 32;
    localparam int MAP_W   = 20;
    localparam int MAP_H   = 15;
    localparam int IDX_W   = 9;

    typedef enum logic [2:0] {
        TILE_EMPTY  = 3'd0,
        TILE_WALL   = 3'd1,
        TILE_BRICK  = 3'd2,
        TILE_BASE_P = 3'd3,
        TILE_BASE_E = 3'd4
    } tile_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } probe_state_e;

    // Row-major map store addressing.
    function automatic logic [IDX_W-1:0] tile_index(input int row, input int col, input int map_w);
        return IDX_W'(row * map_w + col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/map_probe_tile_span.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_span                                                                  |
// | Converts a pixel box into an inclusive tile range plus a map-bounds flag.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tile_span #(
    parameter int TILE_PX = 32,
    parameter int MAP_W   = 20,
    parameter int MAP_H   = 15,
    parameter int CW      = 5
) (
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [5:0]    w,
    input  logic [5:0]    h,
    output logic [CW-1:0] col0,
    output logic [CW-1:0] col1,
    output logic [CW-1:0] row0,
    output logic [CW-1:0] row1,
    output logic          out_of_bounds
);

    localparam logic [10:0] C_X_LIMIT = 11'(MAP_W * TILE_PX);
    localparam logic [10:0] C_Y_LIMIT = 11'(MAP_H * TILE_PX);

    logic [10:0] w_x_end;
    logic [10:0] w_y_end;

    // Last covered pixel; 11 bits so a box hanging off a 1023 origin cannot wrap.
    assign w_x_end = {1'b0, x} + {5'd0, w} - 11'd1;
    assign w_y_end = {1'b0, y} + {5'd0, h} - 11'd1;

    assign col0 = CW'(x / TILE_PX);
    assign row0 = CW'(y / TILE_PX);
    assign col1 = CW'(w_x_end / TILE_PX);
    assign row1 = CW'(w_y_end / TILE_PX);

    assign out_of_bounds = (w_x_end >= C_X_LIMIT) || (w_y_end >= C_Y_LIMIT);

endmodule
`default_nettype wire

// File: rtl/map_probe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | map_probe                                                                  |
// | Box-vs-tilemap collision query: scans covered tiles one per cycle.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module map_probe #(
    parameter int TILE_PX = map_pkg::TILE_PX,
    parameter int MAP_W   = map_pkg::MAP_W,
    parameter int MAP_H   = map_pkg::MAP_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_x,
    input  logic [9:0] req_y,
    input  logic [5:0] req_w,
    input  logic [5:0] req_h,
    output logic [8:0] map_idx,
    input  logic [2:0] map_tile,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_blocked,
    output logic [8:0] resp_idx,
    output logic [2:0] resp_code
);
    import map_pkg::*;

    localparam int CW = $clog2((MAP_W > MAP_H) ? MAP_W : MAP_H);

    logic [CW-1:0] w_col0;
    logic [CW-1:0] w_col1;
    logic [CW-1:0] w_row0;
    logic [CW-1:0] w_row1;
    logic          w_oob;
    logic          w_last_tile;

    probe_state_e  r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col0;
    logic [CW-1:0] r_col1;
    logic [CW-1:0] r_row1;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic          r_resp_blocked;
    logic [8:0]    r_resp_idx;
    logic [2:0]    r_resp_code;
    logic [8:0]    r_map_idx;

    tile_span #(
        .TILE_PX (TILE_PX),
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H),
        .CW      (CW)
    ) u_span (
        .x             (req_x),
        .y             (req_y),
        .w             (req_w),
        .h             (req_h),
        .col0          (w_col0),
        .col1          (w_col1),
        .row0          (w_row0),
        .row1          (w_row1),
        .out_of_bounds (w_oob)
    );

    assign w_last_tile = (r_col == r_col1) && (r_row == r_row1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_col0         <= '0;
            r_col1         <= '0;
            r_row1         <= '0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_blocked <= 1'b0;
            r_resp_idx     <= '0;
            r_resp_code    <= '0;
            r_map_idx      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        if (w_oob) begin
                            // Leaving the map counts as hitting a wall; no scan needed.
                            r_state        <= ST_DONE;
                            r_resp_valid   <= 1'b1;
                            r_resp_blocked <= 1'b1;
                            r_resp_idx     <= '0;
                            r_resp_code    <= TILE_WALL;
                        end else begin
                            r_state   <= ST_SCAN;
                            r_col     <= w_col0;
                            r_row     <= w_row0;
                            r_col0    <= w_col0;
                            r_col1    <= w_col1;
                            r_row1    <= w_row1;
                            r_map_idx <= tile_index(int'(w_row0), int'(w_col0), MAP_W);
                        end
                    end
                end
                ST_SCAN: begin
                    if (map_tile != TILE_EMPTY) begin
                        r_state        <= ST_DONE;
                        r_resp_valid   <= 1'b1;
                        r_resp_blocked <= 1'b1;
                        r_resp_idx     <= r_map_idx;
                        r_resp_code    <= map_tile;
                        r_map_idx      <= '0;
                    end else if (w_last_tile) begin
                        r_state        <= ST_DONE;
                        r_resp_valid   <= 1'b1;
                        r_resp_blocked <= 1'b0;
                        r_resp_idx     <= '0;
                        r_resp_code    <= '0;
                        r_map_idx      <= '0;
                    end else if (r_col == r_col1) begin
                        r_col     <= r_col0;
                        r_row     <= r_row + 1'b1;
                        r_map_idx <= tile_index(int'(r_row) + 1, int'(r_col0), MAP_W);
                    end else begin
                        r_col     <= r_col + 1'b1;
                        r_map_idx <= r_map_idx + 9'd1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state        <= ST_IDLE;
                        r_req_ready    <= 1'b1;
                        r_resp_valid   <= 1'b0;
                        r_resp_blocked <= 1'b0;
                        r_resp_idx     <= '0;
                        r_resp_code    <= '0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_req_ready    <= 1'b1;
                    r_resp_valid   <= 1'b0;
                    r_resp_blocked <= 1'b0;
                    r_resp_idx     <= '0;
                    r_resp_code    <= '0;
                    r_map_idx      <= '0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_blocked = r_resp_blocked;
    assign resp_idx     = r_resp_idx;
    assign resp_code    = r_resp_code;
    assign map_idx      = r_map_idx;

endmodule
`default_nettype wire

// File: tb/tb_map_probe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_map_probe                                                               |
// | Directed collision queries against a fixed map layout.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_map_probe;
    import map_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic [5:0] req_w;
    logic [5:0] req_h;
    logic [8:0] map_idx;
    logic [2:0] map_tile;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_blocked;
    logic [8:0] resp_idx;
    logic [2:0] resp_code;

    int checks;
    int errors;

    map_probe dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_w        (req_w),
        .req_h        (req_h),
        .map_idx      (map_idx),
        .map_tile     (map_tile),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_blocked (resp_blocked),
        .resp_idx     (resp_idx),
        .resp_code    (resp_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Power-up layout: border walls, a brick at 28, enemy base at 29, a wall at 62.
    function automatic logic [2:0] layout(input int idx);
        int row;
        int col;
        row = idx / 20;
        col = idx % 20;
        if (row == 0 || row == 14 || col == 0 || col == 19) return TILE_WALL;
        if (idx == 28) return TILE_BRICK;
        if (idx == 29) return TILE_BASE_E;
        if (idx == 62) return TILE_WALL;
        return TILE_EMPTY;
    endfunction

    always_comb map_tile = layout(int'(map_idx));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_query(input string tag, input int x, input int y, input int w, input int h,
                             input int exp_lat, input int exp_first, input int exp_blk,
                             input int exp_idx, input int exp_code, input int hold);
        int lat;
        int waited;
        waited = 0;
        while (!req_ready && waited < 10) begin
            tick();
            waited++;
        end
        check({tag, " req_ready before issue"}, int'(req_ready), 1);
        req_x = 10'(x);
        req_y = 10'(y);
        req_w = 6'(w);
        req_h = 6'(h);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        if (exp_lat > 1) check({tag, " first map_idx"}, int'(map_idx), exp_first);
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " blocked"}, int'(resp_blocked), exp_blk);
        check({tag, " idx"}, int'(resp_idx), exp_idx);
        check({tag, " code"}, int'(resp_code), exp_code);
        check({tag, " req_ready in DONE"}, int'(req_ready), 0);
        check({tag, " map_idx in DONE"}, int'(map_idx), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, int'(resp_valid), 1);
            check({tag, " hold idx"}, int'(resp_idx), exp_idx);
            check({tag, " hold code"}, int'(resp_code), exp_code);
            check({tag, " hold req_ready"}, int'(req_ready), 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " resp_valid after consume"}, int'(resp_valid), 0);
        check({tag, " req_ready after consume"}, int'(req_ready), 1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Reset      = 1'b1;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        resp_ready = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        check("reset req_ready", int'(req_ready), 1);
        check("reset resp_valid", int'(resp_valid), 0);
        check("reset resp_blocked", int'(resp_blocked), 0);
        check("reset resp_idx", int'(resp_idx), 0);
        check("reset resp_code", int'(resp_code), 0);
        check("reset map_idx", int'(map_idx), 0);

        //        tag     x    y    w   h  lat first blk idx code hold
        run_query("q1",  40,  40, 16, 16, 2,  21, 0,   0, 0, 0);
        run_query("q2", 250,  40, 16, 16, 3,  27, 1,  28, 2, 0);
        run_query("q3", 630, 100, 16, 16, 1,   0, 1,   0, 1, 0);
        run_query("q4",  32,  32, 32, 32, 2,  21, 0,   0, 0, 0);
        run_query("q5", 288,  32, 32, 32, 2,  29, 1,  29, 4, 5);
        run_query("q6",  48,  48, 32, 32, 5,  21, 0,   0, 0, 0);
        run_query("q7",  48,  80, 32, 32, 5,  41, 1,  62, 1, 0);
        run_query("q8",   0,   0,  8,  8, 2,   0, 1,   0, 1, 0);
        run_query("q9", 624,  32, 16, 16, 2,  39, 1,  39, 1, 0);
        run_query("q10",100, 470, 16, 16, 1,   0, 1,   0, 1, 0);
        run_query("q11",100, 464, 16, 16, 2, 283, 1, 283, 1, 0);
        run_query("q12",250, 100, 16, 16, 3,  67, 0,   0, 0, 0);

        // Reset landing in the second scan cycle of the brick query.
        req_x = 10'd250;
        req_y = 10'd40;
        req_w = 6'd16;
        req_h = 6'd16;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rst scan first idx", int'(map_idx), 27);
        tick();
        check("rst scan second idx", int'(map_idx), 28);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midscan reset req_ready", int'(req_ready), 1);
        check("midscan reset resp_valid", int'(resp_valid), 0);
        check("midscan reset resp_blocked", int'(resp_blocked), 0);
        check("midscan reset resp_idx", int'(resp_idx), 0);
        check("midscan reset resp_code", int'(resp_code), 0);
        check("midscan reset map_idx", int'(map_idx), 0);
        run_query("post_rst", 250, 40, 16, 16, 3, 27, 1, 28, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/map_probe.md
MAP_PROBE -- requirements
Module: map_probe

Interface
REQ-001 Parameter TILE_PX, default 32, meaning tile edge length in pixels.
REQ-002 Parameter MAP_W, default 20, meaning map width in tiles.
REQ-003 Parameter MAP_H, default 15, meaning map height in tiles; map index = row*MAP_W + col, range 0..299.
REQ-004 Clk  input  1  system clock; the block uses this single clock only.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  a collision query is presented.
REQ-007 req_ready  output  1  the block accepts a query this cycle.
REQ-008 req_x, req_y  input  10 each  top-left pixel of the query box.
REQ-009 req_w, req_h  input  6 each  box size in pixels; legal range 1..32.
REQ-010 map_idx  output  9  tile index being read from the map store.
REQ-011 map_tile  input  3  tile code at map_idx, valid in the same cycle (combinational read).
REQ-012 resp_valid  output  1  result available; held until consumed.
REQ-013 resp_ready  input  1  consumer takes the result.
REQ-014 resp_blocked  output  1  the box overlaps at least one non-empty tile or leaves the map.
REQ-015 resp_idx  output  9  index of the first blocking tile; 0 if not blocked.
REQ-016 resp_code  output  3  code of the first blocking tile; 0 if not blocked.

Function
REQ-017 Tile codes SHALL be EMPTY=0, WALL=1, BRICK=2, BASE_P=3, BASE_E=4; any nonzero code blocks.
REQ-018 The FSM SHALL have states IDLE, SCAN, DONE; req_ready SHALL be 1 only in IDLE.
REQ-019 Handshake: a query SHALL be accepted on a cycle with req_valid=1 and req_ready=1; inputs are registered at acceptance.
REQ-020 At acceptance the block SHALL compute col0=x/TILE_PX, col1=(x+w-1)/TILE_PX, row0=y/TILE_PX, row1=(y+h-1)/TILE_PX, using 11-bit sums.
REQ-021 If x+w-1 >= MAP_W*TILE_PX or y+h-1 >= MAP_H*TILE_PX, the block SHALL go directly to DONE with blocked=1, idx=0, code=WALL, without scanning.
REQ-022 Otherwise it SHALL enter SCAN, visiting tiles row-major (row0..row1, col0..col1), one tile per cycle, driving map_idx for the current tile.
REQ-023 In SCAN, a nonzero map_tile SHALL end the scan: that index and code are latched and the FSM moves to DONE next cycle.
REQ-024 If the last tile is empty, the FSM SHALL move to DONE with blocked=0, idx=0, code=0.
REQ-025 Latency: the response SHALL assert k+1 cycles after acceptance, where k = tiles visited (1..4); the out-of-bounds case asserts 1 cycle after acceptance.
REQ-026 In DONE, resp_valid=1 and the resp_* outputs SHALL be stable until resp_ready=1; the FSM then returns to IDLE on the next edge.
REQ-027 A new query SHALL NOT be accepted in the cycle the response is consumed; req_ready rises the following cycle.
REQ-028 req_valid in SCAN/DONE SHALL be ignored; map_idx SHALL be 0 outside SCAN.

Reset
REQ-029 On Reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-scan or with a pending response.
REQ-030 Reset values SHALL be: req_ready=1 on the first post-reset cycle, resp_valid=0, resp_blocked=0, resp_idx=0, resp_code=0, map_idx=0.

Structure
REQ-031 Package map_pkg SHALL hold TILE_PX, MAP_W, MAP_H, the tile-code enum, and the map index width; the map store uses the same package.
REQ-032 The span computation (REQ-020/021) SHALL be a combinational sub-module tile_span producing col0, col1, row0, row1, and out_of_bounds.

Verification
REQ-033 Map loaded with its power-up layout; query x=40,y=40,w=16,h=16 -> one tile (idx 21) visited; resp at +2 cycles with blocked=0, idx=0, code=0.
REQ-034 Query x=250,y=40,w=16,h=16 -> visits idx 27 (empty), then 28; resp blocked=1, idx=28, code=2, at +3 cycles.
REQ-035 Query x=630,y=100,w=16,h=16 -> no scan; resp at +1 cycle with blocked=1, idx=0, code=1.
REQ-036 Query x=32,y=32,w=32,h=32 -> exactly one tile (idx 21) visited; x=288,y=32,w=32,h=32 -> idx 29, blocked=1, code=4.
REQ-037 Hold resp_ready=0 for 5 cycles in DONE -> outputs stable and req_ready=0 throughout; release -> IDLE next edge, req_ready=1 one cycle later.
REQ-038 Assert Reset during the second SCAN cycle of the REQ-034 query -> next cycle IDLE, resp_valid=0, all resp_* are 0, and a new query is accepted normally.
